hsv_threshold_calibrator: RTL and testbench
===========================================

Name: hsv_threshold_calibrator

Overview:
- Owns the six HSV threshold registers that feed the pixel threshold/mask stage.
- Supports manual register writes and a one-shot auto-calibration.
- Auto-calibration captures min/max H, S and V over a fixed on-screen box for one full frame, widens the range by a margin, then applies all six thresholds atomically.
- Sits in the pixel clock domain, between the RGB-to-HSV converter output and the threshold stage.

Parameters:
- FRAME_W, 1280, active pixels per line.
- FRAME_H, 720, active lines per frame.
- BOX_X0, 608, left column of the sample box.
- BOX_Y0, 328, top line of the sample box.
- BOX_W, 64, sample box width.
- BOX_H, 64, sample box height.

Ports:
- clk_in  input  1  pixel clock.
- rst_in  input  1  synchronous, active-high reset.
- valid_in  input  1  h/s/v and hcount/vcount describe an active pixel this cycle.
- hcount_in  input  11  pixel column, aligned with h/s/v.
- vcount_in  input  10  pixel line, aligned with h/s/v.
- h_in, s_in, v_in  input  8 each  HSV pixel.
- start_in  input  1  calibration request pulse.
- margin_in  input  8  widening applied to each captured range.
- cfg_we_in  input  1  manual register write strobe.
- cfg_sel_in  input  3  register select: 0 h_low, 1 h_high, 2 s_low, 3 s_high, 4 v_low, 5 v_high; 6 and 7 ignored.
- cfg_data_in  input  8  manual write data.
- h_thresh_low, h_thresh_high, s_thresh_low, s_thresh_high, v_thresh_low, v_thresh_high  output  8 each  registered thresholds.
- busy_out  output  1  high in ARM, SAMPLE and APPLY.
- done_out  output  1  one-cycle pulse at the end of APPLY.
- empty_out  output  1  sticky flag: last calibration saw no box pixels.

Behaviour:
- Clock and reset: one clock (clk_in); reset rst_in is synchronous and active-high.
- Reset values: all *_low = 0, all *_high = 255, busy_out = 0, done_out = 0, empty_out = 0, state IDLE, sample count 0.
- Reset mid-calibration aborts immediately, with the same values as above.
- States:
  - IDLE: start_in = 1 -> ARM; clear empty_out.
  - ARM: wait for valid_in with hcount = 0 and vcount = 0. That cycle goes to SAMPLE and is itself evaluated as a SAMPLE pixel.
  - SAMPLE: accumulate. Leave on valid_in with hcount = FRAME_W-1 and vcount = FRAME_H-1, after evaluating that pixel -> APPLY.
  - APPLY: one cycle, then IDLE.
- Accumulators: on entry to SAMPLE, mins = 255, maxes = 0, count = 0.
- In-box pixel: valid_in and BOX_X0 <= hcount < BOX_X0+BOX_W and BOX_Y0 <= vcount < BOX_Y0+BOX_H. Each in-box pixel updates the per-channel min/max and increments a 16-bit saturating count.
- Cycles with valid_in = 0 change nothing.
- APPLY with count > 0: computed in 9-bit arithmetic, then all six registers written in the same edge.
  - low = min - margin, saturating at 0.
  - high = max + margin, saturating at 255.
- APPLY with count = 0: thresholds unchanged; empty_out = 1.
- done_out is asserted during the APPLY cycle; new thresholds are visible the cycle after.
- Hue wrap-around (red spanning 255 to 0) is not handled. Ranges are literal min..max.
- start_in outside IDLE is ignored.
- Manual writes:
  - cfg_we_in in IDLE writes the selected register next edge.
  - cfg_we_in in any other state is dropped.
  - cfg_we_in and start_in together in IDLE: write performed and calibration started.
- No low <= high consistency check on manual writes. The threshold stage then simply masks everything off.
- Frame with fewer than FRAME_W x FRAME_H valid pixels: stays in SAMPLE until a pixel at the final coordinate arrives.

Test Plan:
- Reset: after rst_in, lows = 0, highs = 255, busy = 0, done = 0, empty = 0. Assert rst_in in SAMPLE -> same values next cycle, IDLE.
- Uniform box: start; frame where box pixels are h=100, s=150, v=200, all others 0; margin 10 -> h 90..110, s 140..160, v 190..210; done_out one pulse; busy low next cycle.
- Range and saturation: box h spans 3..250, s 0..255, v 128; margin 20 -> h 0..255, s 0..255, v 108..148.
- Boundary: only pixels at (BOX_X0-1, BOX_Y0) and (BOX_X0+BOX_W, BOX_Y0) carry h=50, box is uniform h=200; margin 0 -> h 200..200. Pixel (BOX_X0+BOX_W-1, BOX_Y0+BOX_H-1) with h=201 -> h 200..201.
- Empty / no-box frame: BOX_Y0 set beyond FRAME_H in a test param -> thresholds unchanged, empty_out = 1, done pulses. Next start clears empty_out.
- Manual writes: in IDLE, cfg_sel = 3, data = 77 -> s_thresh_high = 77 next cycle. During SAMPLE, cfg_sel = 0 write -> h_thresh_low unchanged. start_in pulse during SAMPLE -> no restart, single done.

Source files
------------

// File: rtl/hsv_threshold_calibrator.sv
// Owns the six HSV threshold registers; supports manual writes and a one-frame
// auto-calibration that captures min/max over a fixed box and widens by a margin.
module hsv_threshold_calibrator #(
    parameter int FRAME_W = 1280,
    parameter int FRAME_H = 720,
    parameter int BOX_X0  = 608,
    parameter int BOX_Y0  = 328,
    parameter int BOX_W   = 64,
    parameter int BOX_H   = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [7:0]  h_in,
    input  logic [7:0]  s_in,
    input  logic [7:0]  v_in,
    input  logic        start_in,
    input  logic [7:0]  margin_in,
    input  logic        cfg_we_in,
    input  logic [2:0]  cfg_sel_in,
    input  logic [7:0]  cfg_data_in,
    output logic [7:0]  h_thresh_low,
    output logic [7:0]  h_thresh_high,
    output logic [7:0]  s_thresh_low,
    output logic [7:0]  s_thresh_high,
    output logic [7:0]  v_thresh_low,
    output logic [7:0]  v_thresh_high,
    output logic        busy_out,
    output logic        done_out,
    output logic        empty_out
);

    // Box bounds are one bit wider than the counters so an end past the frame still compares correctly.
    localparam logic [11:0] LP_X_LO   = 12'(BOX_X0);
    localparam logic [11:0] LP_X_HI   = 12'(BOX_X0 + BOX_W);
    localparam logic [10:0] LP_Y_LO   = 11'(BOX_Y0);
    localparam logic [10:0] LP_Y_HI   = 11'(BOX_Y0 + BOX_H);
    localparam logic [10:0] LP_H_LAST = 11'(FRAME_W - 1);
    localparam logic [9:0]  LP_V_LAST = 10'(FRAME_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_SAMPLE,
        S_APPLY
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        w_sampleEn;
    logic        w_accInit;
    logic        w_inBox;
    logic        w_frameStart;
    logic        w_frameEnd;

    logic [7:0]  r_hMin, r_hMax, r_sMin, r_sMax, r_vMin, r_vMax;
    logic [15:0] r_count;
    logic [7:0]  w_hMinBase, w_hMaxBase, w_sMinBase, w_sMaxBase, w_vMinBase, w_vMaxBase;
    logic [15:0] w_cntBase;

    logic [7:0]  r_hLow, r_hHigh, r_sLow, r_sHigh, r_vLow, r_vHigh;
    logic        r_empty;

    function automatic logic [7:0] satSub(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[8] ? 8'd0 : diff[7:0];
    endfunction

    function automatic logic [7:0] satAdd(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    assign w_frameStart = valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign w_frameEnd   = valid_in && (hcount_in == LP_H_LAST) && (vcount_in == LP_V_LAST);
    assign w_inBox      = valid_in
                       && ({1'b0, hcount_in} >= LP_X_LO) && ({1'b0, hcount_in} < LP_X_HI)
                       && ({1'b0, vcount_in} >= LP_Y_LO) && ({1'b0, vcount_in} < LP_Y_HI);

    // The ARM cycle that sees the frame origin both resets and updates the accumulators.
    assign w_hMinBase = w_accInit ? 8'hFF : r_hMin;
    assign w_sMinBase = w_accInit ? 8'hFF : r_sMin;
    assign w_vMinBase = w_accInit ? 8'hFF : r_vMin;
    assign w_hMaxBase = w_accInit ? 8'h00 : r_hMax;
    assign w_sMaxBase = w_accInit ? 8'h00 : r_sMax;
    assign w_vMaxBase = w_accInit ? 8'h00 : r_vMax;
    assign w_cntBase  = w_accInit ? 16'd0 : r_count;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_sampleEn  = 1'b0;
        w_accInit   = 1'b0;
        busy_out    = (r_state != S_IDLE);
        done_out    = (r_state == S_APPLY);
        case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    w_nextState = S_ARM;
                end
            end
            S_ARM: begin
                if (w_frameStart) begin
                    w_sampleEn  = 1'b1;
                    w_accInit   = 1'b1;
                    w_nextState = w_frameEnd ? S_APPLY : S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_sampleEn = 1'b1;
                if (w_frameEnd) begin
                    w_nextState = S_APPLY;
                end
            end
            S_APPLY: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_hMin  <= 8'hFF;
            r_sMin  <= 8'hFF;
            r_vMin  <= 8'hFF;
            r_hMax  <= 8'h00;
            r_sMax  <= 8'h00;
            r_vMax  <= 8'h00;
            r_count <= 16'd0;
        end else if (w_sampleEn) begin
            if (w_inBox) begin
                r_hMin  <= (h_in < w_hMinBase) ? h_in : w_hMinBase;
                r_sMin  <= (s_in < w_sMinBase) ? s_in : w_sMinBase;
                r_vMin  <= (v_in < w_vMinBase) ? v_in : w_vMinBase;
                r_hMax  <= (h_in > w_hMaxBase) ? h_in : w_hMaxBase;
                r_sMax  <= (s_in > w_sMaxBase) ? s_in : w_sMaxBase;
                r_vMax  <= (v_in > w_vMaxBase) ? v_in : w_vMaxBase;
                r_count <= (w_cntBase == 16'hFFFF) ? w_cntBase : w_cntBase + 16'd1;
            end else begin
                r_hMin  <= w_hMinBase;
                r_sMin  <= w_sMinBase;
                r_vMin  <= w_vMinBase;
                r_hMax  <= w_hMaxBase;
                r_sMax  <= w_sMaxBase;
                r_vMax  <= w_vMaxBase;
                r_count <= w_cntBase;
            end
        end
    end

    // Thresholds change only by an IDLE manual write or all at once in APPLY.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_hLow  <= 8'h00;
            r_hHigh <= 8'hFF;
            r_sLow  <= 8'h00;
            r_sHigh <= 8'hFF;
            r_vLow  <= 8'h00;
            r_vHigh <= 8'hFF;
            r_empty <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_empty <= 1'b0;
                    end
                    if (cfg_we_in) begin
                        case (cfg_sel_in)
                            3'd0:    r_hLow  <= cfg_data_in;
                            3'd1:    r_hHigh <= cfg_data_in;
                            3'd2:    r_sLow  <= cfg_data_in;
                            3'd3:    r_sHigh <= cfg_data_in;
                            3'd4:    r_vLow  <= cfg_data_in;
                            3'd5:    r_vHigh <= cfg_data_in;
                            default: ;
                        endcase
                    end
                end
                S_APPLY: begin
                    if (r_count != 16'd0) begin
                        r_hLow  <= satSub(r_hMin, margin_in);
                        r_hHigh <= satAdd(r_hMax, margin_in);
                        r_sLow  <= satSub(r_sMin, margin_in);
                        r_sHigh <= satAdd(r_sMax, margin_in);
                        r_vLow  <= satSub(r_vMin, margin_in);
                        r_vHigh <= satAdd(r_vMax, margin_in);
                    end else begin
                        r_empty <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign h_thresh_low  = r_hLow;
    assign h_thresh_high = r_hHigh;
    assign s_thresh_low  = r_sLow;
    assign s_thresh_high = r_sHigh;
    assign v_thresh_low  = r_vLow;
    assign v_thresh_high = r_vHigh;
    assign empty_out     = r_empty;

endmodule

// File: tb/tb_hsv_threshold_calibrator.sv
// Bench for hsv_threshold_calibrator on a reduced frame; a second instance has its box
// placed below the frame so every calibration there comes back empty.
module tb_hsv_threshold_calibrator;

    localparam int FW   = 16;
    localparam int FH   = 12;
    localparam int BX   = 5;
    localparam int BY   = 4;
    localparam int BW   = 4;
    localparam int BH   = 3;
    localparam int BY_B = 20;

    logic        clk = 1'b0;
    logic        rst, valid, start, cfgWe;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [7:0]  h, s, v, margin, cfgData;
    logic [2:0]  cfgSel;
    logic [7:0]  aTh [6];
    logic [7:0]  bTh [6];
    logic        aBusy, aDone, aEmpty, bBusy, bDone, bEmpty;

    int          total = 0;
    int          bad   = 0;
    int          modelThA [6];
    int          modelThB [6];
    logic        modelEmptyA, modelEmptyB;
    logic [23:0] qA [$];
    logic [23:0] qB [$];
    string       names [6] = '{"hLo", "hHi", "sLo", "sHi", "vLo", "vHi"};

    always #5 clk = ~clk;

    hsv_threshold_calibrator #(
        .FRAME_W(FW), .FRAME_H(FH), .BOX_X0(BX), .BOX_Y0(BY), .BOX_W(BW), .BOX_H(BH)
    ) uA (
        .clk_in(clk), .rst_in(rst), .valid_in(valid), .hcount_in(hcount), .vcount_in(vcount),
        .h_in(h), .s_in(s), .v_in(v), .start_in(start), .margin_in(margin),
        .cfg_we_in(cfgWe), .cfg_sel_in(cfgSel), .cfg_data_in(cfgData),
        .h_thresh_low(aTh[0]), .h_thresh_high(aTh[1]), .s_thresh_low(aTh[2]),
        .s_thresh_high(aTh[3]), .v_thresh_low(aTh[4]), .v_thresh_high(aTh[5]),
        .busy_out(aBusy), .done_out(aDone), .empty_out(aEmpty)
    );

    hsv_threshold_calibrator #(
        .FRAME_W(FW), .FRAME_H(FH), .BOX_X0(BX), .BOX_Y0(BY_B), .BOX_W(BW), .BOX_H(BH)
    ) uB (
        .clk_in(clk), .rst_in(rst), .valid_in(valid), .hcount_in(hcount), .vcount_in(vcount),
        .h_in(h), .s_in(s), .v_in(v), .start_in(start), .margin_in(margin),
        .cfg_we_in(cfgWe), .cfg_sel_in(cfgSel), .cfg_data_in(cfgData),
        .h_thresh_low(bTh[0]), .h_thresh_high(bTh[1]), .s_thresh_low(bTh[2]),
        .s_thresh_high(bTh[3]), .v_thresh_low(bTh[4]), .v_thresh_high(bTh[5]),
        .busy_out(bBusy), .done_out(bDone), .empty_out(bEmpty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit inBox(input int x, input int y, input int by);
        return (x >= BX) && (x < BX + BW) && (y >= by) && (y < by + BH);
    endfunction

    function automatic int qMin(input logic [23:0] q [$], input int sh);
        int m = 255;
        foreach (q[i]) if (int'((q[i] >> sh) & 24'hFF) < m) m = int'((q[i] >> sh) & 24'hFF);
        return m;
    endfunction

    function automatic int qMax(input logic [23:0] q [$], input int sh);
        int m = 0;
        foreach (q[i]) if (int'((q[i] >> sh) & 24'hFF) > m) m = int'((q[i] >> sh) & 24'hFF);
        return m;
    endfunction

    function automatic int satLo(input int x);
        return (x - int'(margin) < 0) ? 0 : x - int'(margin);
    endfunction

    function automatic int satHi(input int x);
        return (x + int'(margin) > 255) ? 255 : x + int'(margin);
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 6; i++) begin
            modelThA[i] = (i % 2 == 0) ? 0 : 255;
            modelThB[i] = (i % 2 == 0) ? 0 : 255;
        end
        modelEmptyA = 1'b0;
        modelEmptyB = 1'b0;
    endtask

    task automatic applyModel();
        if (qA.size() == 0) modelEmptyA = 1'b1;
        else for (int c = 0; c < 3; c++) begin
            modelThA[2*c]   = satLo(qMin(qA, 16 - 8*c));
            modelThA[2*c+1] = satHi(qMax(qA, 16 - 8*c));
        end
        if (qB.size() == 0) modelEmptyB = 1'b1;
        else for (int c = 0; c < 3; c++) begin
            modelThB[2*c]   = satLo(qMin(qB, 16 - 8*c));
            modelThB[2*c+1] = satHi(qMax(qB, 16 - 8*c));
        end
    endtask

    task automatic checkThresh(input string tag);
        for (int i = 0; i < 6; i++) begin
            checkOutput({tag, "/A.", names[i]}, 16'(aTh[i]), 16'(modelThA[i]));
            checkOutput({tag, "/B.", names[i]}, 16'(bTh[i]), 16'(modelThB[i]));
        end
    endtask

    task automatic checkStatus(input string tag, input logic expBusy, input logic expDone);
        checkOutput({tag, "/A.busy"}, 16'(aBusy), 16'(expBusy));
        checkOutput({tag, "/A.done"}, 16'(aDone), 16'(expDone));
        checkOutput({tag, "/A.empty"}, 16'(aEmpty), 16'(modelEmptyA));
        checkOutput({tag, "/B.busy"}, 16'(bBusy), 16'(expBusy));
        checkOutput({tag, "/B.done"}, 16'(bDone), 16'(expDone));
        checkOutput({tag, "/B.empty"}, 16'(bEmpty), 16'(modelEmptyB));
    endtask

    // Pixel content per test mode; box-relative index k picks the forced extremes.
    function automatic logic [23:0] genPixel(input int mode, input int x, input int y);
        bit         inA;
        int         k;
        logic [7:0] rh, rs, rv;
        inA = inBox(x, y, BY);
        k   = (y - BY) * BW + (x - BX);
        rh  = 8'($urandom_range(0, 255));
        rs  = 8'($urandom_range(0, 255));
        rv  = 8'($urandom_range(0, 255));
        case (mode)
            0: return inA ? {8'd100, 8'd150, 8'd200} : 24'd0;
            1: begin
                if (!inA) return {rh, rs, rv};
                if (k == 0) return {8'd3, 8'd0, 8'd128};
                if (k == 1) return {8'd250, 8'd255, 8'd128};
                return {8'($urandom_range(3, 250)), rs, 8'd128};
            end
            2, 3: begin
                if (mode == 3 && x == BX + BW - 1 && y == BY + BH - 1) return {8'd201, rs, rv};
                return inA ? {8'd200, rs, rv} : {8'd50, rs, rv};
            end
            default: return {rh, rs, rv};
        endcase
    endfunction

    task automatic applyStimulus(input int m);
        margin = 8'(m);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        modelEmptyA = 1'b0;
        modelEmptyB = 1'b0;
        checkStatus("armed", 1'b1, 1'b0);
    endtask

    // Drives one full frame with random valid gaps; optional mid-frame poke or reset.
    task automatic sendFrame(input int mode, input int injectAt, input int abortAt);
        int          aDoneCnt, bDoneCnt, idx;
        logic [23:0] px;
        qA.delete();
        qB.delete();
        aDoneCnt = 0;
        bDoneCnt = 0;
        for (int y = 0; y < FH; y++) begin
            for (int x = 0; x < FW; x++) begin
                idx = y * FW + x;
                if ($urandom_range(0, 3) == 0) begin
                    valid   = 1'b0;
                    hcount  = 11'($urandom_range(0, FW - 1));
                    vcount  = 10'($urandom_range(0, FH - 1));
                    {h, s, v} = 24'($urandom);
                    tick();
                    aDoneCnt += int'(aDone);
                    bDoneCnt += int'(bDone);
                end
                px = genPixel(mode, x, y);
                valid  = 1'b1;
                hcount = 11'(x);
                vcount = 10'(y);
                {h, s, v} = px;
                if (inBox(x, y, BY)) qA.push_back(px);
                if (inBox(x, y, BY_B)) qB.push_back(px);
                if (idx == injectAt) begin
                    start   = 1'b1;
                    cfgWe   = 1'b1;
                    cfgSel  = 3'd0;
                    cfgData = 8'd99;
                end
                if (idx == abortAt) rst = 1'b1;
                tick();
                start = 1'b0;
                cfgWe = 1'b0;
                rst   = 1'b0;
                if (idx == abortAt) begin
                    valid = 1'b0;
                    resetModel();
                    checkThresh("abort");
                    checkStatus("abort", 1'b0, 1'b0);
                    return;
                end
                if (idx == FW * FH - 1) begin
                    checkThresh("preApply");
                    checkStatus("apply", 1'b1, 1'b1);
                end else begin
                    aDoneCnt += int'(aDone);
                    bDoneCnt += int'(bDone);
                end
            end
        end
        valid = 1'b0;
        applyModel();
        tick();
        checkOutput("earlyDoneA", 16'(aDoneCnt), 16'd0);
        checkOutput("earlyDoneB", 16'(bDoneCnt), 16'd0);
        checkThresh("postApply");
        checkStatus("postApply", 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; start = 1'b0; cfgWe = 1'b0; cfgSel = 3'd0; cfgData = 8'd0;
        hcount = 11'd0; vcount = 10'd0; h = 8'd0; s = 8'd0; v = 8'd0; margin = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        resetModel();
        checkThresh("reset");
        checkStatus("reset", 1'b0, 1'b0);

        // Manual writes in IDLE; selects 6/7 are ignored
        cfgWe = 1'b1; cfgSel = 3'd3; cfgData = 8'd77;
        tick();
        modelThA[3] = 77; modelThB[3] = 77;
        checkOutput("manualSHi", 16'(aTh[3]), 16'd77);
        cfgSel = 3'd6; cfgData = 8'd5;
        tick();
        cfgWe = 1'b0;
        checkThresh("manualSel6");

        // Write plus start together, then an ARM phase with decoy pixels
        cfgWe = 1'b1; cfgSel = 3'd1; cfgData = 8'd222;
        applyStimulus(10);
        cfgWe = 1'b0;
        modelThA[1] = 222; modelThB[1] = 222;
        checkThresh("writeAndStart");
        valid = 1'b1; hcount = 11'(BX); vcount = 10'(BY); {h, s, v} = 24'd0;
        tick();
        valid = 1'b0; hcount = 11'd0; vcount = 10'd0;
        tick();
        valid = 1'b1; hcount = 11'd1;
        tick();
        valid = 1'b0;
        checkStatus("armWait", 1'b1, 1'b0);
        sendFrame(0, -1, -1);
        checkOutput("uniHLo", 16'(aTh[0]), 16'd90);
        checkOutput("uniHHi", 16'(aTh[1]), 16'd110);
        checkOutput("uniSLo", 16'(aTh[2]), 16'd140);
        checkOutput("uniSHi", 16'(aTh[3]), 16'd160);
        checkOutput("uniVLo", 16'(aTh[4]), 16'd190);
        checkOutput("uniVHi", 16'(aTh[5]), 16'd210);
        checkOutput("emptyB", 16'(bEmpty), 16'd1);

        // Range and saturation
        applyStimulus(20);
        sendFrame(1, -1, -1);
        checkOutput("rngHLo", 16'(aTh[0]), 16'd0);
        checkOutput("rngHHi", 16'(aTh[1]), 16'd255);
        checkOutput("rngSLo", 16'(aTh[2]), 16'd0);
        checkOutput("rngSHi", 16'(aTh[3]), 16'd255);
        checkOutput("rngVLo", 16'(aTh[4]), 16'd108);
        checkOutput("rngVHi", 16'(aTh[5]), 16'd148);

        // Box edges: neighbours excluded, far corner included
        applyStimulus(0);
        sendFrame(2, -1, -1);
        checkOutput("edgeHLo", 16'(aTh[0]), 16'd200);
        checkOutput("edgeHHi", 16'(aTh[1]), 16'd200);
        applyStimulus(0);
        sendFrame(3, -1, -1);
        checkOutput("cornerHLo", 16'(aTh[0]), 16'd200);
        checkOutput("cornerHHi", 16'(aTh[1]), 16'd201);

        // Random frames; the second gets a write and a start pulse mid-SAMPLE
        applyStimulus($urandom_range(0, 40));
        sendFrame(4, -1, -1);
        applyStimulus($urandom_range(0, 40));
        sendFrame(4, (BY + BH + 1) * FW + 3, -1);
        repeat (3) tick();
        checkStatus("noRestart", 1'b0, 1'b0);

        // Reset in the middle of SAMPLE, then a clean calibration
        applyStimulus(5);
        sendFrame(4, -1, 50);
        tick();
        checkStatus("idleAfterAbort", 1'b0, 1'b0);
        applyStimulus(7);
        sendFrame(0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
